// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter.
// The CPU pushes bytes into a small circular TX FIFO through TXDATA.
// A serialiser drains the FIFO LSB first at a programmable baud divisor.
// Register map (addr[3:2]): 0 TXDATA, 1 STATUS, 2 BAUDDIV, 3 reserved.
module uart_tx_periph #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DIV_DEFAULT = 16'd2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        uart_txd
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] A_TXDATA  = 2'd0;
  localparam logic [1:0] A_STATUS  = 2'd1;
  localparam logic [1:0] A_BAUDDIV = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  // Configuration
  logic [15:0]      r_baud;

  // Serialiser state
  state_t           r_state;
  logic [15:0]      r_bcnt;
  logic [15:0]      r_limit;
  logic [2:0]       r_bitidx;
  logic [7:0]       r_shreg;
  logic             r_txd;

  // Decode and handshake wires
  logic [1:0]       w_sel;
  logic             w_push;
  logic             w_push_ok;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_busy;
  logic             w_wrap;
  logic [7:0]       w_head;
  logic [31:0]      w_status;
  logic             w_unused;

  assign w_sel     = addr[3:2];
  assign w_push    = we && (w_sel == A_TXDATA);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_busy    = (r_state != S_IDLE);
  // The counter limit is latched at every bit start, so a BAUDDIV write
  // only takes effect from the following bit.
  assign w_wrap    = (r_bcnt == (r_limit - 16'd1));
  assign w_head    = r_mem[r_rptr];
  // The serialiser takes a byte when idle, or back-to-back at the end of
  // a stop bit; both need data already present before the edge.
  assign w_pop     = !w_empty &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_wrap));
  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign uart_txd  = r_txd;

  // Only addr[3:2] is decoded and BAUDDIV is 16 bits wide.
  assign w_unused  = ^{addr[31:4], addr[1:0], wdata[31:16]};

  // FIFO storage: write the pushed byte into the slot under the write pointer
  // NOTE: the data array has no reset; pointers and count define which
  // entries are valid, so clearing the storage would only add logic.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= wdata[7:0];
    end
  end

  // FIFO pointers, occupancy count and sticky overflow flag
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_push_ok) begin
        r_ovf <= 1'b1;
      end else if (we && (w_sel == A_STATUS) && wdata[3]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Baud divisor register; zero would stall the counter, so it is stored as 1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud <= DIV_DEFAULT;
    end else if (we && (w_sel == A_BAUDDIV)) begin
      r_baud <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
    end
  end

  // 8N1 serialiser: start bit, eight data bits LSB first, stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_bcnt   <= '0;
      r_limit  <= DIV_DEFAULT;
      r_bitidx <= '0;
      r_shreg  <= '0;
      r_txd    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shreg <= w_head;
            r_bcnt  <= '0;
            r_limit <= r_baud;
            r_txd   <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_wrap) begin
            r_txd    <= r_shreg[0];
            r_bitidx <= '0;
            r_bcnt   <= '0;
            r_limit  <= r_baud;
            r_state  <= S_DATA;
          end else begin
            r_bcnt <= r_bcnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_wrap) begin
            r_bcnt  <= '0;
            r_limit <= r_baud;
            if (r_bitidx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shreg  <= {1'b0, r_shreg[7:1]};
              r_txd    <= r_shreg[1];
              r_bitidx <= r_bitidx + 3'd1;
            end
          end else begin
            r_bcnt <= r_bcnt + 16'd1;
          end
        end
        S_STOP: begin
          if (w_wrap) begin
            r_bcnt  <= '0;
            r_limit <= r_baud;
            if (w_pop) begin
              r_shreg <= w_head;
              r_txd   <= 1'b0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_bcnt <= r_bcnt + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  // STATUS word assembled from live state
  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_status              = '0;
    w_status[0]           = w_full;
    w_status[1]           = w_empty;
    w_status[2]           = w_busy;
    w_status[3]           = r_ovf;
    w_status[4 +: CNT_W]  = r_count;
  end

  // Read mux: combinational from addr[3:2] and current state
  always_comb begin
    rdata = '0;
    case (w_sel)
      A_STATUS:  rdata = w_status;
      A_BAUDDIV: rdata = {16'd0, r_baud};
      default:   rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: self-checking bench for uart_tx_periph.
// A frame-level reference model predicts uart_txd and STATUS for every
// cycle of a transaction; directed cases are followed by randomized runs.
module tb_uart_tx_periph;

  localparam int DEPTH   = 8;
  localparam int MAXT    = 2048;
  localparam int DIV_DEF = 2604;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        uart_txd;

  int n_cmp = 0;
  int n_err = 0;

  // Per-cycle expectations, indexed by the edge count since the first push
  logic        exp_txd  [MAXT];
  logic        exp_busy [MAXT];
  int          exp_occ  [MAXT];
  logic        exp_ovf  [MAXT];

  logic [7:0]  g_bytes [16];
  logic        g_ovf = 1'b0;
  int          g_baud = DIV_DEF;

  int          cur_n;
  int          cur_tw;
  int          cur_rst;
  logic [15:0] cur_bnew_raw;

  uart_tx_periph #(
    .FIFO_DEPTH  (DEPTH),
    .DIV_DEFAULT (16'd2604)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .we       (we),
    .wdata    (wdata),
    .rdata    (rdata),
    .uart_txd (uart_txd)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input int occ, input logic ovf, input logic busy);
    logic [31:0] s;
    s    = 32'(occ) << 4;
    s[3] = ovf;
    s[2] = busy;
    s[1] = (occ == 0);
    s[0] = (occ == DEPTH);
    return s;
  endfunction

  // Called at a negedge; the write lands on the next rising edge.
  task automatic bus_write(input logic [1:0] idx, input logic [31:0] d);
    logic [31:0] r;
    r     = $urandom;
    addr  = {r[31:4], idx, r[1:0]};
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] idx, output logic [31:0] d);
    logic [31:0] r;
    r    = $urandom;
    we   = 1'b0;
    addr = {r[31:4], idx, r[1:0]};
    #1;
    d = rdata;
  endtask

  // Inputs for edge e of the current transaction
  task automatic drive(input int e);
    logic [31:0] r;
    logic [31:0] r2;
    r     = $urandom;
    r2    = $urandom;
    rst   = 1'b0;
    we    = 1'b0;
    addr  = {r[31:4], 2'd1, r[1:0]};
    wdata = r2;
    if (e < cur_n) begin
      addr  = {r[31:4], 2'd0, r[1:0]};
      wdata = {r2[31:8], g_bytes[e]};
      we    = 1'b1;
    end
    if (e == cur_tw) begin
      addr  = {r[31:4], 2'd2, r[1:0]};
      wdata = {r2[31:16], cur_bnew_raw};
      we    = 1'b1;
    end
    if (e == cur_rst) rst = 1'b1;
  endtask

  // Reference model: pushes at edges 0..n-1; the transmitter takes the next
  // byte at the first edge (not before the previous frame ends) where the
  // queue holds one; each of the ten bits lasts the divisor in force when
  // the bit starts; the divisor changes to bnew after edge tw.
  task automatic build_model(input int n, input int b0, input int bnew,
                             input int tw, input int rst_edge, output int t_last);
    logic [7:0] q[$];
    int         next_pop;
    logic       ovf;
    logic       pop;
    logic [7:0] b;
    logic       bitv;
    int         ts;
    int         dur;
    for (int i = 0; i < MAXT; i++) begin
      exp_txd[i]  = 1'b1;
      exp_busy[i] = 1'b0;
      exp_occ[i]  = 0;
      exp_ovf[i]  = 1'b0;
    end
    next_pop = 0;
    ovf      = g_ovf;
    t_last   = n;
    for (int t = 0; t < MAXT - 200; t++) begin
      if (t == rst_edge) begin
        q.delete();
        ovf = 1'b0;
        for (int i = t; i < MAXT; i++) begin
          exp_txd[i]  = 1'b1;
          exp_busy[i] = 1'b0;
        end
      end else begin
        pop = (q.size() > 0) && (t >= next_pop);
        if (pop) begin
          b  = q.pop_front();
          ts = t;
          for (int k = 0; k < 10; k++) begin
            if (k == 0)      bitv = 1'b0;
            else if (k == 9) bitv = 1'b1;
            else             bitv = b[k-1];
            dur = (tw >= 0 && ts > tw) ? bnew : b0;
            for (int d = 0; d < dur; d++) begin
              exp_txd[ts+d]  = bitv;
              exp_busy[ts+d] = 1'b1;
            end
            ts += dur;
          end
          next_pop = ts;
          if (ts > t_last) t_last = ts;
        end
        if (t < n) begin
          if (q.size() < DEPTH) q.push_back(g_bytes[t]);
          else                  ovf = 1'b1;
        end
      end
      exp_occ[t] = q.size();
      exp_ovf[t] = ovf;
    end
    if (tw > t_last)       t_last = tw;
    if (rst_edge > t_last) t_last = rst_edge;
    t_last += 3;
  endtask

  // Drive one transaction and compare uart_txd and STATUS every cycle.
  task automatic run_stream(input string tag, input int n, input int b0, input int tw,
                            input logic [15:0] bnew_raw, input int rst_edge);
    int          t_last;
    int          bnew;
    logic [31:0] st;
    bnew = (bnew_raw == 16'd0) ? 1 : int'(bnew_raw);
    build_model(n, b0, bnew, tw, rst_edge, t_last);
    cur_n        = n;
    cur_tw       = tw;
    cur_bnew_raw = bnew_raw;
    cur_rst      = rst_edge;
    drive(0);
    @(negedge clk);
    for (int t = 0; t <= t_last; t++) begin
      check($sformatf("%s txd@%0d", tag, t), {31'd0, uart_txd}, {31'd0, exp_txd[t]});
      read_reg(2'd1, st);
      check($sformatf("%s status@%0d", tag, t), st,
            exp_status(exp_occ[t], exp_ovf[t], exp_busy[t]));
      drive(t + 1);
      @(negedge clk);
    end
    g_ovf = exp_ovf[t_last];
    if (rst_edge >= 0)  g_baud = DIV_DEF;
    else if (tw >= 0)   g_baud = bnew;
    cur_n   = 0;
    cur_tw  = -1;
    cur_rst = -1;
  endtask

  initial begin
    logic [31:0] d;
    int          b;
    int          n;
    int          tw;
    logic [15:0] braw;

    cur_n = 0; cur_tw = -1; cur_rst = -1; cur_bnew_raw = '0;
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("reset txd", {31'd0, uart_txd}, 32'd1);
    read_reg(2'd1, d); check("reset status", d, 32'h0000_0002);
    read_reg(2'd2, d); check("reset bauddiv", d, 32'd2604);
    read_reg(2'd0, d); check("txdata reads zero", d, 32'd0);
    read_reg(2'd3, d); check("reserved reads zero", d, 32'd0);
    bus_write(2'd3, $urandom);
    read_reg(2'd1, d); check("reserved write status", d, 32'h0000_0002);
    read_reg(2'd2, d); check("reserved write bauddiv", d, 32'd2604);

    // Single 0xA5 frame at divisor 4 (upper wdata bits are ignored)
    bus_write(2'd2, 32'hABCD_0004);
    read_reg(2'd2, d); check("bauddiv=4", d, 32'd4);
    g_baud = 4;
    g_bytes[0] = 8'hA5;
    run_stream("a5", 1, 4, -1, 16'd0, -1);

    // Ten back-to-back pushes: ninth accepted, tenth overflows
    for (int i = 0; i < 10; i++) g_bytes[i] = 8'(i);
    run_stream("burst", 10, 4, -1, 16'd0, -1);
    read_reg(2'd1, d); check("overflow sticky", d, 32'h0000_000A);
    bus_write(2'd1, 32'hFFFF_FFF7);
    read_reg(2'd1, d); check("status write bit3=0 keeps overflow", d, 32'h0000_000A);
    bus_write(2'd1, 32'h0000_0008);
    read_reg(2'd1, d); check("overflow cleared", d, 32'h0000_0002);
    g_ovf = 1'b0;
    read_reg(2'd2, d); check("bauddiv untouched by txdata", d, 32'd4);

    // Divisor 0 is stored as 1
    bus_write(2'd2, 32'h0000_0000);
    read_reg(2'd2, d); check("bauddiv 0 reads 1", d, 32'd1);
    g_baud = 1;
    g_bytes[0] = 8'h55;
    run_stream("div1", 1, 1, -1, 16'd0, -1);

    // Divisor 4 -> 8 during data bit 2 (bit 2 spans edges 13..16)
    bus_write(2'd2, 32'd4);
    g_baud = 4;
    g_bytes[0] = 8'h3C;
    run_stream("middiv", 1, 4, 14, 16'd8, -1);
    read_reg(2'd2, d); check("bauddiv after change", d, 32'd8);

    // Reset during data bit 3 (edges 17..20) with three bytes queued
    bus_write(2'd2, 32'd4);
    g_baud = 4;
    for (int i = 0; i < 4; i++) g_bytes[i] = 8'($urandom);
    run_stream("rstmid", 4, 4, -1, 16'd0, 18);
    read_reg(2'd1, d); check("post-reset status", d, 32'h0000_0002);
    read_reg(2'd2, d); check("post-reset bauddiv", d, 32'd2604);

    // Randomized transactions
    for (int it = 0; it < 5; it++) begin
      b = $urandom_range(1, 5);
      bus_write(2'd2, {16'($urandom), 16'(b)});
      g_baud = b;
      read_reg(2'd2, d); check($sformatf("rand%0d bauddiv", it), d, 32'(b));
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) g_bytes[i] = 8'($urandom);
      tw   = ($urandom_range(0, 1) == 1) ? $urandom_range(n, n + 40) : -1;
      braw = 16'($urandom_range(0, 6));
      run_stream($sformatf("rand%0d", it), n, b, tw, braw, -1);
      bus_write(2'd1, 32'h0000_0008);
      g_ovf = 1'b0;
      read_reg(2'd1, d); check($sformatf("rand%0d idle status", it), d, 32'h0000_0002);
      read_reg(2'd2, d); check($sformatf("rand%0d final bauddiv", it), d, 32'(g_baud));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
